// File: rtl/bdi_line_compressor_pkg.sv
// Shared encodings, compressed sizes and FSM states for the BDI line compressor.
package bdi_pkg;

    typedef enum logic [2:0] {
        ZEROS  = 3'd0,
        REPEAT = 3'd1,
        B4D1   = 3'd2,
        B2D1   = 3'd3,
        B4D2   = 3'd4,
        RAW    = 3'd7
    } bdi_enc_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } bdi_state_t;

    localparam logic [5:0] SIZE_ZEROS  = 6'd1;
    localparam logic [5:0] SIZE_REPEAT = 6'd4;
    localparam logic [5:0] SIZE_B4D1   = 6'd13;
    localparam logic [5:0] SIZE_B2D1   = 6'd20;
    localparam logic [5:0] SIZE_B4D2   = 6'd21;
    localparam logic [5:0] SIZE_RAW    = 6'd32;

endpackage

// File: rtl/bdi_line_compressor_fit_check.sv
// Combinational base+delta fit test for one element/delta width pair.
module bdi_fit_check #(
    parameter int LINE_W  = 256,
    parameter int ELEM_W  = 32,
    parameter int DELTA_W = 8,
    localparam int N      = LINE_W / ELEM_W
) (
    input  logic [LINE_W-1:0]    line_i,
    output logic                 ok_o,
    output logic [ELEM_W-1:0]    base_o,
    output logic [N-1:0]         mask_o,
    output logic [N*DELTA_W-1:0] deltas_o
);

    function automatic logic sign_fits(input logic [ELEM_W-1:0] v);
        return v == {{(ELEM_W-DELTA_W){v[DELTA_W-1]}}, v[DELTA_W-1:0]};
    endfunction

    logic [ELEM_W-1:0] elem [N];
    logic [N-1:0]      imm;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elem[i] = line_i[i*ELEM_W +: ELEM_W];
            imm[i]  = sign_fits(elem[i]);
        end
    end

    // Walking downwards leaves the lowest-index non-immediate element as base.
    always_comb begin
        base_o = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (!imm[i]) base_o = elem[i];
        end
    end

    always_comb begin : delta_calc
        logic [ELEM_W-1:0] diff;
        ok_o     = 1'b1;
        mask_o   = imm;
        deltas_o = '0;
        diff     = '0;
        for (int i = 0; i < N; i++) begin
            diff = elem[i] - base_o;
            if (imm[i]) begin
                deltas_o[i*DELTA_W +: DELTA_W] = elem[i][DELTA_W-1:0];
            end else begin
                deltas_o[i*DELTA_W +: DELTA_W] = diff[DELTA_W-1:0];
                if (!sign_fits(diff)) ok_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bdi_line_compressor.sv
// BDI cacheline compressor: tries one encoding per cycle, cheapest first, and emits the first that fits.
module bdi_line_compressor
    import bdi_pkg::*;
#(
    parameter int DATA_FIELD  = 256,
    parameter int TAG_FIELD   = 20,
    parameter int INDEX_WIDTH = 10,
    parameter int META_WIDTH  = 1 + TAG_FIELD + INDEX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_FIELD-1:0] in_line_i,
    input  logic [META_WIDTH-1:0] in_meta_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2:0]            out_encoding_o,
    output logic [5:0]            out_size_o,
    output logic [DATA_FIELD-1:0] out_payload_o,
    output logic [META_WIDTH-1:0] out_meta_o
);

    bdi_state_t            state_q, state_d;
    logic [2:0]            k_q, k_d;
    logic [DATA_FIELD-1:0] line_q;
    logic [META_WIDTH-1:0] meta_q;
    bdi_enc_t              enc_q;
    logic [5:0]            size_q;
    logic [DATA_FIELD-1:0] payload_q;
    logic [META_WIDTH-1:0] out_meta_q;

    logic                  load_in, load_out;
    logic                  cand_ok;
    bdi_enc_t              cand_enc;
    logic [5:0]            cand_size;
    logic [DATA_FIELD-1:0] cand_payload;
    logic                  all_equal;

    logic        ok_4_1, ok_2_1, ok_4_2;
    logic [31:0] base_4_1, base_4_2;
    logic [15:0] base_2_1;
    logic [7:0]  mask_4_1, mask_4_2;
    logic [15:0] mask_2_1;
    logic [63:0]  deltas_4_1;
    logic [127:0] deltas_2_1, deltas_4_2;

    bdi_fit_check #(.LINE_W(DATA_FIELD), .ELEM_W(32), .DELTA_W(8)) u_fit_4_1 (
        .line_i   (line_q),
        .ok_o     (ok_4_1),
        .base_o   (base_4_1),
        .mask_o   (mask_4_1),
        .deltas_o (deltas_4_1)
    );

    bdi_fit_check #(.LINE_W(DATA_FIELD), .ELEM_W(16), .DELTA_W(8)) u_fit_2_1 (
        .line_i   (line_q),
        .ok_o     (ok_2_1),
        .base_o   (base_2_1),
        .mask_o   (mask_2_1),
        .deltas_o (deltas_2_1)
    );

    bdi_fit_check #(.LINE_W(DATA_FIELD), .ELEM_W(32), .DELTA_W(16)) u_fit_4_2 (
        .line_i   (line_q),
        .ok_o     (ok_4_2),
        .base_o   (base_4_2),
        .mask_o   (mask_4_2),
        .deltas_o (deltas_4_2)
    );

    always_comb begin
        all_equal = 1'b1;
        for (int i = 1; i < 8; i++) begin
            if (line_q[i*32 +: 32] != line_q[31:0]) all_equal = 1'b0;
        end
    end

    // k selects the candidate under test; k beyond the last BDI form falls back to RAW.
    always_comb begin
        cand_ok      = 1'b0;
        cand_enc     = RAW;
        cand_size    = SIZE_RAW;
        cand_payload = '0;
        case (k_q)
            3'd0: begin
                cand_ok   = (line_q == '0);
                cand_enc  = ZEROS;
                cand_size = SIZE_ZEROS;
            end
            3'd1: begin
                cand_ok            = all_equal;
                cand_enc           = REPEAT;
                cand_size          = SIZE_REPEAT;
                cand_payload[31:0] = line_q[31:0];
            end
            3'd2: begin
                cand_ok              = ok_4_1;
                cand_enc             = B4D1;
                cand_size            = SIZE_B4D1;
                cand_payload[31:0]   = base_4_1;
                cand_payload[39:32]  = mask_4_1;
                cand_payload[40 +: 64] = deltas_4_1;
            end
            3'd3: begin
                cand_ok               = ok_2_1;
                cand_enc              = B2D1;
                cand_size             = SIZE_B2D1;
                cand_payload[15:0]    = base_2_1;
                cand_payload[31:16]   = mask_2_1;
                cand_payload[32 +: 128] = deltas_2_1;
            end
            3'd4: begin
                cand_ok               = ok_4_2;
                cand_enc              = B4D2;
                cand_size             = SIZE_B4D2;
                cand_payload[31:0]    = base_4_2;
                cand_payload[39:32]   = mask_4_2;
                cand_payload[40 +: 128] = deltas_4_2;
            end
            default: begin
                cand_ok      = 1'b1;
                cand_enc     = RAW;
                cand_size    = SIZE_RAW;
                cand_payload = line_q;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        load_in  = 1'b0;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = CHECK;
                    k_d     = 3'd0;
                    load_in = 1'b1;
                end
            end
            CHECK: begin
                if (cand_ok) begin
                    state_d  = DONE;
                    load_out = 1'b1;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= 3'd0;
            line_q     <= '0;
            meta_q     <= '0;
            enc_q      <= ZEROS;
            size_q     <= '0;
            payload_q  <= '0;
            out_meta_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (load_in) begin
                line_q <= in_line_i;
                meta_q <= in_meta_i;
            end
            if (load_out) begin
                enc_q      <= cand_enc;
                size_q     <= cand_size;
                payload_q  <= cand_payload;
                out_meta_q <= meta_q;
            end
        end
    end

    assign in_ready_o     = (state_q == IDLE);
    assign out_valid_o    = (state_q == DONE);
    assign out_encoding_o = enc_q;
    assign out_size_o     = size_q;
    assign out_payload_o  = payload_q;
    assign out_meta_o     = out_meta_q;

endmodule

// File: tb/tb_bdi_line_compressor.sv
// Randomised bench for bdi_line_compressor against an arithmetic BDI reference model.
module tb_bdi_line_compressor;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_line;
    logic [30:0]  in_meta;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_encoding;
    logic [5:0]   out_size;
    logic [255:0] out_payload;
    logic [30:0]  out_meta;

    int checks    = 0;
    int errors    = 0;
    int cycleCnt  = 0;
    bit monOn     = 0;
    bit zeroCheck = 0;
    bit randomReady = 0;

    typedef struct {
        logic [2:0]   enc;
        logic [5:0]   size;
        logic [255:0] payload;
        logic [30:0]  meta;
        int           lat;
        int           acceptEdge;
    } expT;

    expT expQ[$];

    bdi_line_compressor dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_line_i      (in_line),
        .in_meta_i      (in_meta),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_encoding_o (out_encoding),
        .out_size_o     (out_size),
        .out_payload_o  (out_payload),
        .out_meta_o     (out_meta)
    );

    always #5 clk = ~clk;

    function automatic longint sgn(input longint v, input int w);
        longint half;
        half = longint'(1) << (w - 1);
        return (v >= half) ? v - (half << 1) : v;
    endfunction

    function automatic bit fitsSigned(input longint s, input int d);
        longint lim;
        lim = longint'(1) << (d - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    // Base+delta fit for element width e and delta width d, building the packed payload.
    function automatic bit fitModel(input logic [255:0] line, input int e, input int d,
                                    output logic [255:0] payload);
        int n;
        longint modE, base, diff, dv;
        longint el [32];
        bit imm [32];
        bit found, ok;
        logic [255:0] sh, field;
        n = 256 / e;
        modE = longint'(1) << e;
        base = 0;
        found = 0;
        ok = 1;
        for (int i = 0; i < n; i++) begin
            sh = line >> (i * e);
            el[i] = longint'({32'h0, sh[31:0]}) % modE;
            imm[i] = fitsSigned(sgn(el[i], e), d);
            if (!imm[i] && !found) begin
                base = el[i];
                found = 1;
            end
        end
        payload = 256'(base);
        for (int i = 0; i < n; i++) begin
            payload[e + i] = imm[i];
            if (imm[i]) begin
                dv = el[i] % (longint'(1) << d);
            end else begin
                diff = (el[i] - base + modE) % modE;
                if (!fitsSigned(sgn(diff, e), d)) ok = 0;
                dv = diff % (longint'(1) << d);
            end
            field = 256'(dv);
            payload = payload | (field << (e + n + i * d));
        end
        return ok;
    endfunction

    function automatic void modelCompress(input logic [255:0] line, output logic [2:0] enc,
                                          output logic [5:0] size, output logic [255:0] payload,
                                          output int lat);
        logic [255:0] p;
        bit same;
        same = 1;
        for (int i = 1; i < 8; i++) begin
            if (line[i*32 +: 32] != line[31:0]) same = 0;
        end
        if (line == '0) begin
            enc = 3'd0; size = 6'd1; payload = '0; lat = 1;
        end else if (same) begin
            enc = 3'd1; size = 6'd4; payload = 256'(line[31:0]); lat = 2;
        end else if (fitModel(line, 32, 8, p)) begin
            enc = 3'd2; size = 6'd13; payload = p; lat = 3;
        end else if (fitModel(line, 16, 8, p)) begin
            enc = 3'd3; size = 6'd20; payload = p; lat = 4;
        end else if (fitModel(line, 32, 16, p)) begin
            enc = 3'd4; size = 6'd21; payload = p; lat = 5;
        end else begin
            enc = 3'd7; size = 6'd32; payload = line; lat = 6;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the DUT against the scoreboard, sampled on the falling edge.
    task automatic sampleOutputs();
        bit expValid;
        expT e;
        if (monOn) begin
            expValid = 0;
            if (expQ.size() > 0) expValid = (cycleCnt - expQ[0].acceptEdge) >= expQ[0].lat;
            checkOutput("out_valid", out_valid, expValid);
            checkOutput("in_ready", in_ready, expQ.size() == 0);
            if (zeroCheck) begin
                checkOutput("reset_encoding", out_encoding, 0);
                checkOutput("reset_size", out_size, 0);
                checkOutput("reset_payload", out_payload, 0);
                checkOutput("reset_meta", out_meta, 0);
                zeroCheck = 0;
            end
            if (expValid && out_valid) begin
                e = expQ[0];
                checkOutput("encoding", out_encoding, e.enc);
                checkOutput("size", out_size, e.size);
                checkOutput("payload", out_payload, e.payload);
                checkOutput("meta", out_meta, e.meta);
            end
            if (rst) begin
                expQ.delete();
                zeroCheck = 1;
            end else begin
                if (out_valid && out_ready && expValid && expQ.size() > 0) void'(expQ.pop_front());
                if (in_valid && in_ready) begin
                    modelCompress(in_line, e.enc, e.size, e.payload, e.lat);
                    e.meta = in_meta;
                    e.acceptEdge = cycleCnt + 1;
                    expQ.push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sampleOutputs();
        @(posedge clk);
        cycleCnt++;
        #1;
        if (randomReady) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [255:0] line, input logic [30:0] meta);
        bit acc;
        acc = 0;
        in_line  = line;
        in_meta  = meta;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            acc = in_ready;
            tick();
        end
        checkOutput("accept_timeout", acc, 1);
    endtask

    task automatic waitDone();
        bit done;
        done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            if (expQ.size() == 0 && !out_valid) done = 1;
            else tick();
        end
        checkOutput("drain_timeout", done, 1);
    endtask

    task automatic pinModel(input string name, input logic [255:0] line, input logic [2:0] eEnc,
                            input logic [5:0] eSize, input logic [255:0] ePayload, input int eLat);
        logic [2:0] enc;
        logic [5:0] size;
        logic [255:0] payload;
        int lat;
        modelCompress(line, enc, size, payload, lat);
        checkOutput({name, "_enc"}, enc, eEnc);
        checkOutput({name, "_size"}, size, eSize);
        checkOutput({name, "_payload"}, payload, ePayload);
        checkOutput({name, "_lat"}, lat, eLat);
    endtask

    function automatic logic [255:0] randomLine();
        logic [255:0] l;
        logic [31:0] b;
        int kind, dl;
        l = '0;
        b = $urandom;
        kind = $urandom_range(0, 6);
        for (int i = 0; i < 8; i++) begin
            case (kind)
                0: l[i*32 +: 32] = 32'h0;
                1: l[i*32 +: 32] = b;
                2: begin
                    dl = $urandom_range(0, 255) - 128;
                    l[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'(dl) : b + 32'(dl);
                end
                3: begin
                    for (int h = 0; h < 2; h++) begin
                        dl = $urandom_range(0, 255) - 128;
                        l[i*32 + h*16 +: 16] = b[15:0] + 16'(dl);
                    end
                end
                4: begin
                    dl = $urandom_range(0, 65535) - 32768;
                    l[i*32 +: 32] = b + 32'(dl);
                end
                5: l[i*32 +: 32] = $urandom;
                default: begin
                    dl = $urandom_range(0, 65535) - 32768;
                    l[i*32 +: 32] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255) - 128)
                                                               : b + 32'(dl);
                end
            endcase
        end
        return l;
    endfunction

    function automatic logic [255:0] rawLine();
        logic [255:0] l;
        logic [2:0] enc;
        logic [5:0] size;
        logic [255:0] p;
        int lat;
        l = {8{32'h12345678}} ^ {4{64'h0000_0000_9551_7337}};
        for (int t = 0; t < 20; t++) begin
            l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            modelCompress(l, enc, size, p, lat);
            if (enc == 3'd7) break;
        end
        return l;
    endfunction

    logic [255:0] zeroLine, repLine, b4d1Line, f9Line, b2d1Line, b4d2Line, rawPin, lineA, lineB, lineR;

    initial begin
        void'($urandom(1));
        rst = 1'b1;
        in_valid = 1'b0;
        in_line = '0;
        in_meta = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        zeroCheck = 1;
        monOn = 1;

        zeroLine = '0;
        repLine  = {8{32'hDEADBEEF}};
        for (int i = 0; i < 8; i++) begin
            b4d1Line[i*32 +: 32] = 32'h10000000 + 32'(4 * i);
            b2d1Line[i*32 +: 32] = {16'h1000 + 16'(i), 16'h1000 + 16'(i)};
            b4d2Line[i*32 +: 32] = 32'h10000000 + 32'(i * 32'h1000);
        end
        f9Line = {160'h0, 32'h8000007F, 32'h80000000, 32'h00000005};
        rawPin = {4{64'h87654321_12345678}};

        pinModel("pin_zero", zeroLine, 3'd0, 6'd1, 256'h0, 1);
        pinModel("pin_repeat", repLine, 3'd1, 6'd4, 256'hDEADBEEF, 2);
        pinModel("pin_b4d1", b4d1Line, 3'd2, 6'd13, 256'h1C1814100C080400_00_10000000, 3);
        pinModel("pin_b4d1_mask", f9Line, 3'd2, 6'd13, 256'h00000000007F0005_F9_80000000, 3);
        pinModel("pin_b2d1", b2d1Line, 3'd3, 6'd20, 256'h07070606050504040303020201010000_0000_1000, 4);
        pinModel("pin_b4d2", b4d2Line, 3'd4, 6'd21, 256'h70006000500040003000200010000000_00_10000000, 5);
        pinModel("pin_raw", rawPin, 3'd7, 6'd32, rawPin, 6);

        applyStimulus(zeroLine, 31'h1234_5678); in_valid = 1'b0; waitDone();
        applyStimulus(repLine,  31'h0ABC_DEF0); in_valid = 1'b0; waitDone();
        applyStimulus(b4d1Line, 31'h4000_0001); in_valid = 1'b0; waitDone();
        applyStimulus(f9Line,   31'h7FFF_FFFF); in_valid = 1'b0; waitDone();
        applyStimulus(b2d1Line, 31'h2222_3333); in_valid = 1'b0; waitDone();
        applyStimulus(b4d2Line, 31'h5555_AAAA); in_valid = 1'b0; waitDone();
        applyStimulus(rawPin,   31'h0000_0F0F); in_valid = 1'b0; waitDone();

        // RAW line with the consumer stalled and a second line already waiting.
        begin
            bit seen;
            seen = 0;
            lineA = rawLine();
            lineB = repLine;
            out_ready = 1'b0;
            applyStimulus(lineA, 31'h3141_5926);
            in_line = lineB;
            in_meta = 31'h2718_2818;
            for (int t = 0; t < 20 && !seen; t++) begin
                if (out_valid) seen = 1;
                else tick();
            end
            checkOutput("stall_valid_timeout", seen, 1);
            repeat (3) tick();
            out_ready = 1'b1;
            tick();
            tick();
            in_valid = 1'b0;
            waitDone();
        end

        // Reset while the checker sits at k=2, then a normal zero line.
        lineR = rawLine();
        applyStimulus(lineR, 31'h6666_7777);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(zeroLine, 31'h0101_0101); in_valid = 1'b0; waitDone();

        randomReady = 1;
        for (int n = 0; n < 60; n++) begin
            applyStimulus(randomLine(), 31'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        in_valid = 1'b0;
        waitDone();
        randomReady = 0;
        out_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
